// File: rtl/input_conditioner.sv
// Conditions raw KEY/SW inputs: 2-flop synchronizer plus per-bit debounce, level and pulse outputs.
// Optional key auto-repeat is built when INPUT_CONDITIONER_AUTO_REPEAT_EN is defined.
module input_conditioner #(
   parameter int N_KEYS          = 2,
   parameter int N_SW            = 10,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic              CLOCK_50,
   input  logic              RESETn,
   input  logic [N_KEYS-1:0] KEY,
   input  logic [N_SW-1:0]   SW,
   output logic [N_KEYS-1:0] KEY_DOWN,
   output logic [N_KEYS-1:0] KEY_PRESS,
   output logic [N_KEYS-1:0] KEY_RELEASE,
   output logic [N_SW-1:0]   SW_STABLE,
   output logic [N_SW-1:0]   SW_CHANGE
);

   localparam int NB = N_KEYS + N_SW;
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DB_TC = CW'(DEBOUNCE_CYCLES - 1);
   // Keys are active-low, so their idle (released) level is 1.
   localparam logic [NB-1:0] IDLE_LVL = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("input_conditioner: timing parameter out of range");
   end

   logic [NB-1:0]     w_raw;
   logic [NB-1:0]     r_meta;
   logic [NB-1:0]     r_sync;
   logic [NB-1:0]     r_st;
   logic [NB-1:0]     w_evt;
   logic [CW-1:0]     r_cnt [NB];
   logic [N_KEYS-1:0] w_key_st;
   logic [N_KEYS-1:0] w_press;
   logic [N_KEYS-1:0] w_release;
   logic [N_KEYS-1:0] w_rpt;
   logic [N_KEYS-1:0] r_key_press;
   logic [N_KEYS-1:0] r_key_release;
   logic [N_SW-1:0]   r_sw_change;

   assign w_raw = {SW, KEY};

   always_ff @(posedge CLOCK_50 or negedge RESETn) begin
      if (!RESETn) begin
         r_meta <= IDLE_LVL;
         r_sync <= IDLE_LVL;
      end else begin
         r_meta <= w_raw;
         r_sync <= r_meta;
      end
   end

   always_comb begin
      w_evt = '0;
      for (int i = 0; i < NB; i++) begin
         w_evt[i] = (r_sync[i] != r_st[i]) && (r_cnt[i] == DB_TC);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESETn) begin
      if (!RESETn) begin
         r_st <= IDLE_LVL;
         for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (r_sync[i] == r_st[i]) begin
               r_cnt[i] <= '0;
            end else if (w_evt[i]) begin
               r_st[i]  <= r_sync[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign w_key_st  = r_st[N_KEYS-1:0];
   assign w_press   = w_evt[N_KEYS-1:0] & w_key_st;
   assign w_release = w_evt[N_KEYS-1:0] & ~w_key_st;

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
   // state    | meaning
   // S_IDLE   | key released, no repeat pending
   // S_DELAY  | key held, counting toward first repeat
   // S_REPEAT | key held, repeating every REPEAT_PERIOD
   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rpt_state_t;

   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RCW  = (RMAX < 2) ? 1 : $clog2(RMAX);
   localparam logic [RCW-1:0] RD_TC = RCW'(REPEAT_DELAY - 1);
   localparam logic [RCW-1:0] RP_TC = RCW'(REPEAT_PERIOD - 1);

   rpt_state_t     r_state    [N_KEYS];
   rpt_state_t     w_state_nxt[N_KEYS];
   logic [RCW-1:0] r_rcnt     [N_KEYS];
   logic [RCW-1:0] w_rcnt_nxt [N_KEYS];

   always_ff @(posedge CLOCK_50 or negedge RESETn) begin
      if (!RESETn) begin
         for (int k = 0; k < N_KEYS; k++) begin
            r_state[k] <= S_IDLE;
            r_rcnt[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            r_state[k] <= w_state_nxt[k];
            r_rcnt[k]  <= w_rcnt_nxt[k];
         end
      end
   end

   always_comb begin
      w_rpt = '0;
      for (int k = 0; k < N_KEYS; k++) begin
         w_state_nxt[k] = r_state[k];
         w_rcnt_nxt[k]  = r_rcnt[k];
         // A release wins over any repeat due in the same cycle.
         if (w_release[k]) begin
            w_state_nxt[k] = S_IDLE;
            w_rcnt_nxt[k]  = '0;
         end else begin
            case (r_state[k])
               S_IDLE: begin
                  if (w_press[k]) begin
                     w_state_nxt[k] = S_DELAY;
                     w_rcnt_nxt[k]  = '0;
                  end
               end
               S_DELAY: begin
                  if (r_rcnt[k] == RD_TC) begin
                     w_state_nxt[k] = S_REPEAT;
                     w_rcnt_nxt[k]  = '0;
                     w_rpt[k]       = 1'b1;
                  end else begin
                     w_rcnt_nxt[k] = r_rcnt[k] + RCW'(1);
                  end
               end
               S_REPEAT: begin
                  if (r_rcnt[k] == RP_TC) begin
                     w_rcnt_nxt[k] = '0;
                     w_rpt[k]      = 1'b1;
                  end else begin
                     w_rcnt_nxt[k] = r_rcnt[k] + RCW'(1);
                  end
               end
               default: begin
                  w_state_nxt[k] = S_IDLE;
                  w_rcnt_nxt[k]  = '0;
               end
            endcase
         end
      end
   end
`else
   assign w_rpt = '0;
`endif

   always_ff @(posedge CLOCK_50 or negedge RESETn) begin
      if (!RESETn) begin
         r_key_press   <= '0;
         r_key_release <= '0;
         r_sw_change   <= '0;
      end else begin
         r_key_press   <= w_press | (w_rpt & ~w_release);
         r_key_release <= w_release;
         r_sw_change   <= w_evt[NB-1:N_KEYS];
      end
   end

   assign KEY_DOWN    = ~w_key_st;
   assign KEY_PRESS   = r_key_press;
   assign KEY_RELEASE = r_key_release;
   assign SW_STABLE   = r_st[NB-1:N_KEYS];
   assign SW_CHANGE   = r_sw_change;

endmodule
